// File: rtl/wb_arbiter.sv
// wb_arbiter: collects writeback results from up to four execution sources
// (0=FLU, 1=load, 2=store, 3=FPU). Each source has a small FIFO and a
// combinational bypass, so a result that arrives into an empty FIFO can be
// granted in the same cycle. Two registered scoreboard write ports are fed
// round-robin.
// Handshake: src_valid_i is a one-cycle push with no back-pressure. The
// producer is expected to stall issue while src_credit_low_o is high.
// wb_valid_o is a one-cycle strobe, because the scoreboard always accepts.
// Build option: define WB_ARBITER_FPU_EN to arbitrate the FPU source (index 3).
// Without it, the FPU FIFO is not built, source 3 inputs are ignored, and
// round-robin runs modulo 3.
module wb_arbiter #(
   parameter int FifoDepth   = 2,
   parameter int NrSrc       = 4,
   parameter int TransIdBits = 5,
   parameter int Xlen        = 32,
   parameter int ExBits      = 8
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                flush_i,
   input  logic [NrSrc-1:0]                    src_valid_i,
   input  logic [NrSrc-1:0][TransIdBits-1:0]   src_trans_id_i,
   input  logic [NrSrc-1:0][Xlen-1:0]          src_result_i,
   input  logic [NrSrc-1:0][ExBits-1:0]        src_ex_i,
   output logic [NrSrc-1:0]                    src_credit_low_o,
   output logic                                overflow_o,
   output logic [1:0]                          wb_valid_o,
   output logic [1:0][TransIdBits-1:0]         wb_trans_id_o,
   output logic [1:0][Xlen-1:0]                wb_result_o,
   output logic [1:0][ExBits-1:0]              wb_ex_o
);
   localparam int PtrW = $clog2(FifoDepth);
   localparam int CntW = $clog2(FifoDepth) + 1;
   localparam int EntW = TransIdBits + Xlen + ExBits;
   localparam int RrW  = $clog2(NrSrc);
`ifdef WB_ARBITER_FPU_EN
   localparam int NrAct = NrSrc;
`else
   localparam int NrAct = NrSrc - 1;
   // Source 3 inputs are intentionally left unconnected in this build.
   logic w_unused_fpu;
   assign w_unused_fpu = ^{src_valid_i[NrSrc-1], src_trans_id_i[NrSrc-1],
                           src_result_i[NrSrc-1], src_ex_i[NrSrc-1]};
`endif

   // FIFO storage and bookkeeping, one set per built source
   logic [EntW-1:0]       r_mem  [NrAct][FifoDepth];
   logic [PtrW-1:0]       r_wptr [NrAct];
   logic [PtrW-1:0]       r_rptr [NrAct];
   logic [CntW-1:0]       r_cnt  [NrAct];
   logic [RrW-1:0]        r_rr;
   logic                  r_overflow;

   logic [NrAct-1:0]            w_push, w_pop, w_elig, w_acc, w_drop;
   logic [NrAct-1:0][EntW-1:0]  w_in, w_head;
   logic [CntW-1:0]             w_cnt_nxt [NrAct];
   logic [1:0]                  w_gnt_vld;
   logic [1:0][RrW-1:0]         w_gnt_src;
   logic [RrW-1:0]              w_rr_nxt;
   logic [RrW:0]                w_sum;
   logic [RrW-1:0]              w_idx;

   // Per-source head selection (bypass when empty), push acceptance and next count
   always_comb begin
      w_push    = '0;
      w_elig    = '0;
      w_acc     = '0;
      w_drop    = '0;
      w_in      = '0;
      w_head    = '0;
      w_cnt_nxt = r_cnt;
      for (int s = 0; s < NrAct; s++) begin
         w_in[s]   = {src_trans_id_i[s], src_result_i[s], src_ex_i[s]};
         w_push[s] = src_valid_i[s];
         w_elig[s] = (r_cnt[s] != '0) || w_push[s];
         w_head[s] = (r_cnt[s] != '0) ? r_mem[s][r_rptr[s]] : w_in[s];
         // A full FIFO still takes a push when its head leaves this cycle
         w_acc[s]  = w_push[s] && ((r_cnt[s] != CntW'(FifoDepth)) || w_pop[s]);
         w_drop[s] = w_push[s] && !w_acc[s];
         if (w_acc[s] && !w_pop[s])
            w_cnt_nxt[s] = r_cnt[s] + CntW'(1);
         else if (w_pop[s] && !w_acc[s])
            w_cnt_nxt[s] = r_cnt[s] - CntW'(1);
      end
   end

   // Round-robin pick of up to two eligible sources starting at r_rr
   always_comb begin
      w_gnt_vld = '0;
      w_gnt_src = '0;
      w_pop     = '0;
      w_rr_nxt  = r_rr;
      w_sum     = '0;
      w_idx     = '0;
      for (int k = 0; k < NrAct; k++) begin
         w_sum = {1'b0, r_rr} + (RrW+1)'(k);
         if (w_sum >= (RrW+1)'(NrAct))
            w_sum = w_sum - (RrW+1)'(NrAct);
         w_idx = w_sum[RrW-1:0];
         if (w_elig[w_idx] && !w_gnt_vld[1]) begin
            if (!w_gnt_vld[0]) begin
               w_gnt_vld[0] = 1'b1;
               w_gnt_src[0] = w_idx;
            end else begin
               w_gnt_vld[1] = 1'b1;
               w_gnt_src[1] = w_idx;
            end
            w_pop[w_idx] = 1'b1;
            w_rr_nxt     = (w_idx == RrW'(NrAct-1)) ? '0 : w_idx + RrW'(1);
         end
      end
   end

   // FIFO pointers and counts; reset and flush both empty every FIFO
   always_ff @(posedge clk_i) begin
      for (int s = 0; s < NrAct; s++) begin
         if (rst_i || flush_i) begin
            r_wptr[s] <= '0;
            r_rptr[s] <= '0;
            r_cnt[s]  <= '0;
         end else begin
            if (w_acc[s]) r_wptr[s] <= r_wptr[s] + PtrW'(1);
            if (w_pop[s]) r_rptr[s] <= r_rptr[s] + PtrW'(1);
            r_cnt[s] <= w_cnt_nxt[s];
         end
      end
   end

   // FIFO data write; contents need no reset since counts gate their use
   always_ff @(posedge clk_i) begin
      for (int s = 0; s < NrAct; s++)
         if (w_acc[s]) r_mem[s][r_wptr[s]] <= w_in[s];
   end

   // Sticky overflow: only cleared by reset, unaffected by flush
   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_overflow <= 1'b0;
      else if (!flush_i && (|w_drop))
         r_overflow <= 1'b1;
   end

   // Registered write ports and round-robin pointer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rr          <= '0;
         wb_valid_o    <= '0;
         wb_trans_id_o <= '0;
         wb_result_o   <= '0;
         wb_ex_o       <= '0;
      end else if (flush_i) begin
         r_rr       <= '0;
         wb_valid_o <= '0;
      end else begin
         r_rr       <= w_rr_nxt;
         wb_valid_o <= w_gnt_vld;
         for (int p = 0; p < 2; p++)
            if (w_gnt_vld[p])
               {wb_trans_id_o[p], wb_result_o[p], wb_ex_o[p]} <= w_head[w_gnt_src[p]];
      end
   end

   // Credit-low flags from registered counts (free entries <= 1)
   always_comb begin
      src_credit_low_o = '0;
      for (int s = 0; s < NrAct; s++)
         src_credit_low_o[s] = (r_cnt[s] >= CntW'(FifoDepth - 1));
   end

   assign overflow_o = r_overflow;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by randomized traffic,
// checked against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;
   localparam int D  = 2;
   localparam int NS = 4;
   localparam int IW = 5;
   localparam int XL = 32;
   localparam int EW = 8;
   localparam int W  = IW + XL + EW;
`ifdef WB_ARBITER_FPU_EN
   localparam int NA = 4;
`else
   localparam int NA = 3;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic                   clk = 1'b0;
   logic                   rst, flush;
   logic [NS-1:0]          sv;
   logic [NS-1:0][IW-1:0]  sid;
   logic [NS-1:0][XL-1:0]  sres;
   logic [NS-1:0][EW-1:0]  sex;
   logic [NS-1:0]          credit_low;
   logic                   overflow;
   logic [1:0]             wb_valid;
   logic [1:0][IW-1:0]     wb_id;
   logic [1:0][XL-1:0]     wb_res;
   logic [1:0][EW-1:0]     wb_ex;

   always #5 clk = ~clk;

   wb_arbiter #(.FifoDepth(D), .NrSrc(NS), .TransIdBits(IW), .Xlen(XL), .ExBits(EW)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .src_valid_i(sv), .src_trans_id_i(sid), .src_result_i(sres), .src_ex_i(sex),
      .src_credit_low_o(credit_low), .overflow_o(overflow),
      .wb_valid_o(wb_valid), .wb_trans_id_o(wb_id), .wb_result_o(wb_res), .wb_ex_o(wb_ex)
   );

   // ---------------- reference model / scoreboard ----------------
   logic [W-1:0] exp_q [NS][$];
   int           rr_m;
   bit           ovf_m;
   logic [1:0]   exp_v;
   logic [1:0][W-1:0] exp_d;
   int           n_vec  = 0;
   int           n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear(input bit keep_ovf);
      for (int s = 0; s < NS; s++) exp_q[s].delete();
      rr_m = 0;
      if (!keep_ovf) ovf_m = 1'b0;
   endtask

   // One clock of the reference behaviour, given the inputs now driven
   task automatic model_step();
      logic [W-1:0] head [NS];
      bit elig [NS];
      bit gnt  [NS];
      int n_g;
      int s;
      exp_v = '0;
      exp_d = '0;
      if (flush) begin
         model_clear(1'b1);
         return;
      end
      for (int i = 0; i < NS; i++) begin
         gnt[i]  = 1'b0;
         elig[i] = (i < NA) && ((exp_q[i].size() > 0) || sv[i]);
         head[i] = (exp_q[i].size() > 0) ? exp_q[i][0] : {sid[i], sres[i], sex[i]};
      end
      n_g = 0;
      for (int k = 0; k < NA; k++) begin
         s = (rr_m + k) % NA;
         if (elig[s] && n_g < 2) begin
            exp_v[n_g] = 1'b1;
            exp_d[n_g] = head[s];
            gnt[s] = 1'b1;
            n_g++;
         end
      end
      // pointer moves to one past the last source that was granted
      for (int k = NA - 1; k >= 0; k--) begin
         s = (rr_m + k) % NA;
         if (gnt[s]) begin
            rr_m = (s + 1) % NA;
            break;
         end
      end
      for (int i = 0; i < NA; i++) begin
         if (gnt[i]) begin
            if (exp_q[i].size() > 0) begin
               void'(exp_q[i].pop_front());
               if (sv[i]) exp_q[i].push_back({sid[i], sres[i], sex[i]});
            end
         end else if (sv[i]) begin
            if (exp_q[i].size() < D) exp_q[i].push_back({sid[i], sres[i], sex[i]});
            else ovf_m = 1'b1;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      sv = '0; flush = 1'b0;
      sid = '0; sres = '0; sex = '0;
   endtask

   task automatic set_src(input int s, input logic [IW-1:0] id, input logic [XL-1:0] res);
      sv[s] = 1'b1; sid[s] = id; sres[s] = res; sex[s] = EW'($urandom);
   endtask

   task automatic rand_inputs(input int pct);
      for (int s = 0; s < NS; s++) begin
         sv[s]   = ($urandom_range(0, 99) < pct);
         sid[s]  = IW'($urandom);
         sres[s] = $urandom;
         sex[s]  = EW'($urandom);
      end
      flush = ($urandom_range(0, 99) < 3);
   endtask

   // Called at the falling edge with inputs driven; returns at the next falling edge
   task automatic cycle();
      logic [NS-1:0] exp_cl;
      exp_cl = '0;
      for (int s = 0; s < NA; s++) exp_cl[s] = (exp_q[s].size() >= D - 1);
      chk("credit_low", 64'(credit_low), 64'(exp_cl));
      model_step();
      @(posedge clk); #1;
      chk("wb_valid", 64'(wb_valid), 64'(exp_v));
      for (int p = 0; p < 2; p++)
         if (exp_v[p])
            chk($sformatf("wb_port%0d", p), 64'({wb_id[p], wb_res[p], wb_ex[p]}), 64'(exp_d[p]));
      chk("overflow", 64'(overflow), 64'(ovf_m));
      @(negedge clk);
   endtask

   // Reset with random traffic on the inputs to show reset dominates
   task automatic do_reset();
      rand_inputs(80);
      rst = 1'b1;
      @(posedge clk); #1;
      model_clear(1'b0);
      chk("rst_valid",    64'(wb_valid), 64'(0));
      chk("rst_id",       64'(wb_id),    64'(0));
      chk("rst_result",   64'(wb_res),   64'(0));
      chk("rst_ex",       64'(wb_ex),    64'(0));
      chk("rst_overflow", 64'(overflow), 64'(0));
      chk("rst_credit",   64'(credit_low), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      rst = 1'b1;
      idle_inputs();
      model_clear(1'b0);
      @(negedge clk);
      do_reset();

      // single FLU result: one-cycle latency, then idle
      set_src(0, 5'd5, 32'hAB);
      cycle();
      chk("flu_id", 64'(wb_id[0]), 64'd5);
      chk("flu_result", 64'(wb_res[0]), 64'hAB);
      idle_inputs();
      cycle();
      chk("flu_done", 64'(wb_valid), 64'd0);

      // all sources at once from rr=0
      do_reset();
      for (int s = 0; s < NS; s++) set_src(s, IW'(s + 1), 32'h100 + s);
      cycle();
      chk("all4_p0", 64'(wb_id[0]), 64'd1);
      chk("all4_p1", 64'(wb_id[1]), 64'd2);
      idle_inputs();
      cycle();
      cycle();

      // load pushes three in a row while the others keep pushing
      do_reset();
      for (int c = 0; c < 3; c++) begin
         for (int s = 0; s < NS; s++)
            set_src(s, (s == 1) ? IW'(6 + c) : IW'(16 + 4 * c + s), $urandom);
         cycle();
      end
      for (int c = 0; c < 3; c++) begin
         for (int s = 0; s < NS; s++)
            if (s != 1) set_src(s, IW'(28 + s), $urandom);
         sv[1] = 1'b0;
         cycle();
      end
      idle_inputs();
      repeat (4) cycle();

      // flush with buffered entries plus a new push
      for (int s = 0; s < NS; s++) set_src(s, IW'(s + 10), $urandom);
      cycle();
      set_src(0, 5'd20, 32'h55);
      flush = 1'b1;
      cycle();
      chk("flush_valid", 64'(wb_valid), 64'd0);
      idle_inputs();
      cycle();
      chk("flush_empty", 64'(wb_valid), 64'd0);

      // FPU-only traffic
      set_src(3, 5'd9, 32'h99);
      cycle();
      idle_inputs();
      cycle();

      // randomized traffic with occasional flush and mid-run reset
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            rand_inputs((c < 300) ? 85 : 45);
            cycle();
         end
      end
      idle_inputs();
      repeat (6) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
